// File: rtl/onehot_key_pkg.sv
// Shared constants and types for the debounced one-hot key capture block.
package onehot_key_pkg;

    localparam int unsigned NUM_KEYS         = 8;
    localparam int unsigned DEFAULT_DEBOUNCE = 4;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // Isolates the lowest set bit; all-zero input gives all-zero output.
    function automatic key_vec_t lowest_set(input key_vec_t v);
        return v & (~v + key_vec_t'(1));
    endfunction

endpackage

// File: rtl/onehot_key_capture_if.sv
// Key request lines in, one-hot code handshake and overrun flag out.
interface onehot_key_capture_if;
    import onehot_key_pkg::*;

    key_vec_t key_in;
    logic     ready;
    key_vec_t d_out;
    logic     valid;
    logic     overrun;

    modport master (
        output key_in,
        output ready,
        input  d_out,
        input  valid,
        input  overrun
    );

    modport slave (
        input  key_in,
        input  ready,
        output d_out,
        output valid,
        output overrun
    );

endinterface

// File: rtl/key_debounce.sv
// One key line: two-flop synchronizer, stability counter and a registered
// single-cycle pulse on each debounced 0->1 transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_expire;

    assign w_differ = (r_sync2 != r_level);
    // Counter already holds DEBOUNCE_CYCLES-1 stable samples; this one completes the run.
    assign w_expire = w_differ && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_rise  <= w_expire && !r_level;
            if (!w_differ || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_expire) begin
                r_level <= ~r_level;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/onehot_key_capture.sv
// Debounces eight key lines, queues press events per line and offers them one
// at a time, lowest index first, as a one-hot code over a valid/ready handshake.
module onehot_key_capture
    import onehot_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned CNT_W           = 8
) (
    input logic                 clk,
    input logic                 rst,
    onehot_key_capture_if.slave bus
);

    key_vec_t w_rise;
    key_vec_t w_sel;
    key_vec_t w_take;
    logic     w_load;

    key_vec_t r_pend;
    key_vec_t r_dout;
    logic     r_valid;
    logic     r_overrun;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_line
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_key  (bus.key_in[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_load = !r_valid || bus.ready;
    assign w_sel  = lowest_set(r_pend);
    assign w_take = w_load ? w_sel : '0;

    // A rise landing on a bit being consumed this cycle is kept as a fresh event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_take) | w_rise;
            r_overrun <= |(w_rise & r_pend & ~w_take);
            if (w_load) begin
                r_dout  <= w_sel;
                r_valid <= |r_pend;
            end
        end
    end

    assign bus.d_out   = r_dout;
    assign bus.valid   = r_valid;
    assign bus.overrun = r_overrun;

endmodule
